// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings: status codes, icodes and register indices used by
// the write-back stage and its register file.
package y86_pkg;

  typedef enum logic [2:0] {
    STAT_BUB = 3'd0,
    STAT_AOK = 3'd1,
    STAT_HLT = 3'd2,
    STAT_ADR = 3'd3,
    STAT_INS = 3'd4
  } stat_t;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [3:0] RRSP  = 4'h4;
  localparam logic [3:0] RNONE = 4'hF;

  // Any status that stops the machine once it reaches write-back.
  function automatic logic is_fault(input logic [2:0] s);
    return (s == STAT_HLT) || (s == STAT_ADR) || (s == STAT_INS);
  endfunction

endpackage

// File: rtl/regfile_2r2w.sv
// NREG x 64-bit program register file: two combinational read ports and two
// synchronous write ports, where port M beats port E on an address clash.
module regfile_2r2w
  import y86_pkg::*;
#(
  parameter int NREG = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        we_e_i,
  input  logic [3:0]  waddr_e_i,
  input  logic [63:0] wdata_e_i,
  input  logic        we_m_i,
  input  logic [3:0]  waddr_m_i,
  input  logic [63:0] wdata_m_i,
  input  logic [3:0]  raddr_a_i,
  input  logic [3:0]  raddr_b_i,
  output logic [63:0] rdata_a_o,
  output logic [63:0] rdata_b_o
);

  logic [63:0] regs_w [NREG];

  // Index 4'hF is outside 0..NREG-1, so it can never match an entry below.
  for (genvar gi = 0; gi < NREG; gi++) begin : g_reg
    logic [63:0] val_q;

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        val_q <= '0;
      end else if (we_m_i && (waddr_m_i == 4'(gi))) begin
        val_q <= wdata_m_i;
      end else if (we_e_i && (waddr_e_i == 4'(gi))) begin
        val_q <= wdata_e_i;
      end
    end

    assign regs_w[gi] = val_q;
  end

  // No write-to-read bypass: decode forwarding handles same-cycle hazards.
  always_comb begin
    rdata_a_o = '0;
    rdata_b_o = '0;
    if (raddr_a_i != RNONE) rdata_a_o = regs_w[raddr_a_i];
    if (raddr_b_i != RNONE) rdata_b_o = regs_w[raddr_b_i];
  end

endmodule

// File: rtl/wb_regfile.sv
// Y86-64 write-back stage: W pipeline register, program register file,
// sticky halt flag and retired-instruction counter.
module wb_regfile
  import y86_pkg::*;
#(
  parameter int NREG      = 15,
  parameter int RET_CNT_W = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [2:0]           M_stat,
  input  logic [3:0]           M_icode,
  input  logic [3:0]           M_dstE,
  input  logic [63:0]          M_valE,
  input  logic [3:0]           M_dstM,
  input  logic [63:0]          m_valM,
  input  logic                 W_stall,
  input  logic                 W_bubble,
  input  logic [3:0]           d_srcA,
  input  logic [3:0]           d_srcB,
  output logic [63:0]          d_rvalA,
  output logic [63:0]          d_rvalB,
  output logic [2:0]           W_stat,
  output logic [3:0]           W_icode,
  output logic [3:0]           W_dstE,
  output logic [63:0]          W_valE,
  output logic [3:0]           W_dstM,
  output logic [63:0]          W_valM,
  output logic                 halted,
  output logic [RET_CNT_W-1:0] retired
);

  logic [2:0]           w_stat_q;
  logic [3:0]           w_icode_q;
  logic [3:0]           w_dste_q;
  logic [63:0]          w_vale_q;
  logic [3:0]           w_dstm_q;
  logic [63:0]          w_valm_q;
  logic                 halted_q;
  logic [RET_CNT_W-1:0] retired_q;

  logic wr_ok;
  logic we_e;
  logic we_m;

  // Stall wins over bubble, so both together hold the register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      w_stat_q  <= STAT_BUB;
      w_icode_q <= I_NOP;
      w_dste_q  <= RNONE;
      w_vale_q  <= '0;
      w_dstm_q  <= RNONE;
      w_valm_q  <= '0;
    end else if (W_stall) begin
      w_stat_q  <= w_stat_q;
    end else if (W_bubble) begin
      w_stat_q  <= STAT_BUB;
      w_icode_q <= I_NOP;
      w_dste_q  <= RNONE;
      w_vale_q  <= '0;
      w_dstm_q  <= RNONE;
      w_valm_q  <= '0;
    end else begin
      w_stat_q  <= M_stat;
      w_icode_q <= M_icode;
      w_dste_q  <= M_dstE;
      w_vale_q  <= M_valE;
      w_dstm_q  <= M_dstM;
      w_valm_q  <= m_valM;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      halted_q  <= 1'b0;
      retired_q <= '0;
    end else begin
      if (is_fault(w_stat_q)) halted_q <= 1'b1;
      if (wr_ok && !W_stall) retired_q <= retired_q + RET_CNT_W'(1);
    end
  end

  assign wr_ok = !halted_q && (w_stat_q == STAT_AOK);
  assign we_e  = wr_ok && (w_dste_q != RNONE);
  assign we_m  = wr_ok && (w_dstm_q != RNONE);

  regfile_2r2w #(.NREG(NREG)) u_rf (
    .clk       (clk),
    .rst_n     (rst_n),
    .we_e_i    (we_e),
    .waddr_e_i (w_dste_q),
    .wdata_e_i (w_vale_q),
    .we_m_i    (we_m),
    .waddr_m_i (w_dstm_q),
    .wdata_m_i (w_valm_q),
    .raddr_a_i (d_srcA),
    .raddr_b_i (d_srcB),
    .rdata_a_o (d_rvalA),
    .rdata_b_o (d_rvalB)
  );

  assign W_stat  = w_stat_q;
  assign W_icode = w_icode_q;
  assign W_dstE  = w_dste_q;
  assign W_valE  = w_vale_q;
  assign W_dstM  = w_dstm_q;
  assign W_valM  = w_valm_q;
  assign halted  = halted_q;
  assign retired = retired_q;

endmodule

// File: tb/tb_wb_regfile.sv
// Directed bench for wb_regfile: reset, writes, popq priority, stall/bubble,
// halt stickiness and reset recovery, with hand-computed expectations.
module tb_wb_regfile;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  M_stat;
  logic [3:0]  M_icode;
  logic [3:0]  M_dstE;
  logic [63:0] M_valE;
  logic [3:0]  M_dstM;
  logic [63:0] m_valM;
  logic        W_stall;
  logic        W_bubble;
  logic [3:0]  d_srcA;
  logic [3:0]  d_srcB;
  logic [63:0] d_rvalA;
  logic [63:0] d_rvalB;
  logic [2:0]  W_stat;
  logic [3:0]  W_icode;
  logic [3:0]  W_dstE;
  logic [63:0] W_valE;
  logic [3:0]  W_dstM;
  logic [63:0] W_valM;
  logic        halted;
  logic [31:0] retired;

  int vectors = 0;
  int errors  = 0;

  wb_regfile dut (
    .clk(clk), .rst_n(rst_n),
    .M_stat(M_stat), .M_icode(M_icode), .M_dstE(M_dstE), .M_valE(M_valE),
    .M_dstM(M_dstM), .m_valM(m_valM),
    .W_stall(W_stall), .W_bubble(W_bubble),
    .d_srcA(d_srcA), .d_srcB(d_srcB), .d_rvalA(d_rvalA), .d_rvalB(d_rvalB),
    .W_stat(W_stat), .W_icode(W_icode), .W_dstE(W_dstE), .W_valE(W_valE),
    .W_dstM(W_dstM), .W_valM(W_valM),
    .halted(halted), .retired(retired)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_m(input logic [2:0] st, input logic [3:0] ic,
                       input logic [3:0] de, input logic [63:0] ve,
                       input logic [3:0] dm, input logic [63:0] vm);
    M_stat = st; M_icode = ic; M_dstE = de; M_valE = ve; M_dstM = dm; m_valM = vm;
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; W_stall = 1'b0; W_bubble = 1'b0; d_srcA = 4'h0; d_srcB = 4'h0;
    set_m(3'd0, 4'h1, 4'hF, 64'h0, 4'hF, 64'h0);
    tick(); tick();
    rst_n = 1'b1;

    // 1: reset state and all reads zero (including RNONE)
    for (int i = 0; i < 16; i++) begin
      d_srcA = 4'(i); d_srcB = 4'(15 - i);
      tick();
      chk($sformatf("rst_rdA[%0d]", i), d_rvalA, 64'h0);
      chk($sformatf("rst_rdB[%0d]", 15 - i), d_rvalB, 64'h0);
    end
    chk("rst_W_stat", W_stat, 3'd0);
    chk("rst_W_icode", W_icode, 4'h1);
    chk("rst_W_dstE", W_dstE, 4'hF);
    chk("rst_W_dstM", W_dstM, 4'hF);
    chk("rst_halted", halted, 1'b0);
    chk("rst_retired", retired, 32'd0);

    // 2: OPQ to %rbx
    set_m(3'd1, 4'h6, 4'd3, 64'h1122334455667788, 4'hF, 64'h0);
    d_srcA = 4'd3; d_srcB = 4'd4;
    tick();
    chk("t2_W_dstE", W_dstE, 4'd3);
    chk("t2_W_valE", W_valE, 64'h1122334455667788);
    chk("t2_no_bypass", d_rvalA, 64'h0);
    // 3: popq %rsp style, dstE==dstM=4, valM must win
    set_m(3'd1, 4'hB, 4'd4, 64'h100, 4'd4, 64'h200);
    tick();
    chk("t2_R3", d_rvalA, 64'h1122334455667788);
    chk("t2_retired", retired, 32'd1);
    chk("t3_R4_before", d_rvalB, 64'h0);
    set_m(3'd0, 4'h1, 4'hF, 64'h0, 4'hF, 64'h0);
    tick();
    chk("t3_R4_valM", d_rvalB, 64'h200);
    chk("t3_retired", retired, 32'd2);
    chk("t3_W_stat_bub", W_stat, 3'd0);

    // 4: stall with AOK held while M changes
    set_m(3'd1, 4'h3, 4'd6, 64'hAAAA, 4'hF, 64'h0);
    tick();
    W_stall = 1'b1;
    set_m(3'd1, 4'h3, 4'd7, 64'hBBBB, 4'hF, 64'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("t4_hold_dstE[%0d]", i), W_dstE, 4'd6);
      chk($sformatf("t4_hold_valE[%0d]", i), W_valE, 64'hAAAA);
      chk($sformatf("t4_hold_ret[%0d]", i), retired, 32'd2);
    end
    W_stall = 1'b0;
    d_srcA = 4'd6; d_srcB = 4'd7;
    tick();
    chk("t4_release_ret", retired, 32'd3);
    chk("t4_release_dstE", W_dstE, 4'd7);
    chk("t4_R6", d_rvalA, 64'hAAAA);
    set_m(3'd0, 4'h1, 4'hF, 64'h0, 4'hF, 64'h0);
    tick();
    chk("t4_R7", d_rvalB, 64'hBBBB);
    chk("t4_ret4", retired, 32'd4);

    // 5: stall+bubble holds; bubble alone injects BUB
    set_m(3'd1, 4'h3, 4'd8, 64'h88, 4'hF, 64'h0);
    tick();
    W_stall = 1'b1; W_bubble = 1'b1;
    set_m(3'd1, 4'h3, 4'd9, 64'h99, 4'hF, 64'h0);
    tick();
    chk("t5_sb_dstE", W_dstE, 4'd8);
    chk("t5_sb_stat", W_stat, 3'd1);
    chk("t5_sb_ret", retired, 32'd4);
    W_stall = 1'b0;
    tick();
    chk("t5_bub_stat", W_stat, 3'd0);
    chk("t5_bub_dstE", W_dstE, 4'hF);
    chk("t5_bub_ret", retired, 32'd5);
    d_srcA = 4'd9; d_srcB = 4'd8;
    tick();
    chk("t5_bub_ret2", retired, 32'd5);
    chk("t5_R9_unwritten", d_rvalA, 64'h0);
    chk("t5_R8", d_rvalB, 64'h88);
    W_bubble = 1'b0;

    // 6: HLT then AOK write to %rbp must be blocked
    set_m(3'd2, 4'h0, 4'hF, 64'h0, 4'hF, 64'h0);
    d_srcA = 4'd5;
    tick();
    chk("t6_W_stat_hlt", W_stat, 3'd2);
    chk("t6_halt_not_yet", halted, 1'b0);
    set_m(3'd1, 4'h3, 4'd5, 64'h55, 4'hF, 64'h0);
    tick();
    chk("t6_halted", halted, 1'b1);
    chk("t6_W_dstE", W_dstE, 4'd5);
    set_m(3'd0, 4'h1, 4'hF, 64'h0, 4'hF, 64'h0);
    tick();
    tick();
    chk("t6_R5_blocked", d_rvalA, 64'h0);
    chk("t6_ret_frozen", retired, 32'd5);
    chk("t6_halted_sticky", halted, 1'b1);

    // reset clears halt, counter and registers; writes resume afterwards
    rst_n = 1'b0;
    d_srcB = 4'd3;
    tick();
    rst_n = 1'b1;
    chk("t6_rst_halted", halted, 1'b0);
    chk("t6_rst_ret", retired, 32'd0);
    chk("t6_rst_R3", d_rvalB, 64'h0);
    set_m(3'd1, 4'h3, 4'd5, 64'h55, 4'hF, 64'h0);
    tick();
    set_m(3'd0, 4'h1, 4'hF, 64'h0, 4'hF, 64'h0);
    tick();
    chk("t6_R5_after_rst", d_rvalA, 64'h55);
    chk("t6_ret_after_rst", retired, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
